traffic_intersection: RTL and testbench
=======================================

TRAFFIC_INTERSECTION -- requirements
Module: traffic_intersection

Interface
REQ-001 Parameter CNT_W, default 6: countdown width.
REQ-002 Parameter T_GREEN, default 24: green dwell load value.
REQ-003 Parameter T_YELLOW, default 6: yellow dwell load value.
REQ-004 Parameter T_ALLRED, default 2: all-red clearance load value.
REQ-005 Parameter T_PED, default 10: pedestrian-walk load value.
REQ-006 Parameter T_FLASH, default 3: flash half-period load value.
REQ-007 Port Clk  in  1: single clock; all state updates on the rising edge.
REQ-008 Port Rst_n  in  1: asynchronous, active-low reset.
REQ-009 Port PedReq  in  1: pedestrian button, level-sampled each cycle.
REQ-010 Port NightMode  in  1: request for flashing mode.
REQ-011 Ports A_Red, A_Yellow, A_Green  out  1 each: main-road lamps.
REQ-012 Ports B_Red, B_Yellow, B_Green  out  1 each: side-road lamps.
REQ-013 Port Walk  out  1: pedestrian walk lamp.
REQ-014 Port Cnt  out  CNT_W: remaining countdown in the current stage.
REQ-015 Port CurrStage  out  3: current stage encoding.

Function
REQ-016 Stages SHALL be A_GRN=0, A_YEL=1, CLR_A=2, B_GRN=3, B_YEL=4, CLR_B=5, PED=6, FLASH=7.
REQ-017 Each cycle, if Cnt!=0, Cnt SHALL decrement by 1 and the stage SHALL hold; if Cnt==0, the stage SHALL transition and Cnt SHALL load the new stage's value, so each stage dwells load+1 cycles.
REQ-018 Transitions: A_GRN->A_YEL->CLR_A->B_GRN->B_YEL->CLR_B; CLR_B->FLASH if NightMode, else PED if PedPending, else A_GRN; PED->A_GRN.
REQ-019 CLR_A SHALL go to FLASH when NightMode=1 at its Cnt==0, otherwise to B_GRN.
REQ-020 Load values: GRN=T_GREEN, YEL=T_YELLOW, CLR=T_ALLRED, PED=T_PED, FLASH=T_FLASH.
REQ-021 Lamps: the road in green/yellow shows only that lamp; the other road shows red; CLR and PED show both reds; Walk=1 only in PED.
REQ-022 An internal PedPending SHALL set on any cycle with PedReq=1, and clear on the edge entering PED; clear takes priority on that edge; PedReq during PED is ignored.
REQ-023 In FLASH, a phase bit SHALL toggle at each Cnt==0 while NightMode=1; A_Yellow=phase, B_Red=phase, all other lamps 0.
REQ-024 In FLASH, NightMode=0 at Cnt==0 SHALL transition to CLR_B with Cnt=T_ALLRED and phase cleared.
REQ-025 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-026 Each T_* value SHALL be between 1 and 2**CNT_W-1; a violation SHALL be flagged by an elaboration-time check.

Reset
REQ-027 Rst_n=0 SHALL immediately force CurrStage=CLR_B, Cnt=T_ALLRED, A_Red=B_Red=1, other lamps 0, Walk=0, PedPending=0, phase=0.
REQ-028 Assertion mid-stage SHALL abandon the stage; after release, the first edge SHALL decrement Cnt from T_ALLRED.

Structure
REQ-029 Stage encodings and the load-value function SHALL reside in package traffic_pkg.
REQ-030 The countdown SHALL be the sub-module tl_countdown (load, load value, zero flag), parametrised by CNT_W.

Verification
REQ-031 Reset release, inputs 0, defaults -> CLR_B for 3 cycles, A_GRN for 25, A_YEL for 7, CLR_A for 3, B_GRN for 25; Cnt counts 24..0 in each green.
REQ-032 One-cycle PedReq pulse during B_GRN -> after CLR_B: PED for 11 cycles with Walk=1 and both reds, then A_GRN; the next cycle shows no PED.
REQ-033 PedReq held high through PED -> exactly one PED per cycle through the sequence.
REQ-034 NightMode=1 during A_GRN -> FLASH entered after CLR_A; A_Yellow/B_Red toggle every 4 cycles; deassert -> CLR_B (3 cycles) then A_GRN.
REQ-035 Rst_n pulsed low mid-B_YEL with Cnt=3 -> same cycle: CurrStage=5, Cnt=2, both reds, PedPending cleared.
REQ-036 CNT_W=4, T_GREEN=15 -> green lasts 16 cycles; T_GREEN=16 -> elaboration error.

Source files
------------

// File: rtl/traffic_intersection_pkg.sv
// Traffic controller shared types: stage encoding, lamp bundle,
// dwell-load and lamp-decode helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    CLR_A = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    CLR_B = 3'd5,
    PED   = 3'd6,
    FLASH = 3'd7
  } stage_e;

  typedef struct packed {
    logic a_red;
    logic a_yel;
    logic a_grn;
    logic b_red;
    logic b_yel;
    logic b_grn;
    logic walk;
  } lamps_t;

  localparam lamps_t LAMPS_RST = 7'b100_100_0;

  function automatic bit t_fits(int t, int w);
    return (t >= 1) && (t <= (1 << w) - 1);
  endfunction

  function automatic int load_of(
    stage_e s, int t_grn, int t_yel,
    int t_clr, int t_ped, int t_flash);
    case (s)
      A_GRN, B_GRN: return t_grn;
      A_YEL, B_YEL: return t_yel;
      CLR_A, CLR_B: return t_clr;
      PED:          return t_ped;
      default:      return t_flash;
    endcase
  endfunction

  function automatic lamps_t lamps_of(
    stage_e s, logic phase);
    lamps_t l;
    l = '0;
    unique case (s)
      A_GRN: begin l.a_grn = 1'b1; l.b_red = 1'b1; end
      A_YEL: begin l.a_yel = 1'b1; l.b_red = 1'b1; end
      B_GRN: begin l.b_grn = 1'b1; l.a_red = 1'b1; end
      B_YEL: begin l.b_yel = 1'b1; l.a_red = 1'b1; end
      CLR_A, CLR_B: begin
        l.a_red = 1'b1;
        l.b_red = 1'b1;
      end
      PED: begin
        l.a_red = 1'b1;
        l.b_red = 1'b1;
        l.walk  = 1'b1;
      end
      FLASH: begin
        l.a_yel = phase;
        l.b_red = phase;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_intersection_if.sv
// Controller I/O bundle: button/night inputs, lamps, Walk,
// countdown and stage. slave = controller, master = environment.
interface traffic_intersection_if #(
  parameter int CNT_W = 6
);
  logic             PedReq;
  logic             NightMode;
  logic             A_Red;
  logic             A_Yellow;
  logic             A_Green;
  logic             B_Red;
  logic             B_Yellow;
  logic             B_Green;
  logic             Walk;
  logic [CNT_W-1:0] Cnt;
  logic [2:0]       CurrStage;

  modport master (
    output PedReq, NightMode,
    input  A_Red, A_Yellow, A_Green,
    input  B_Red, B_Yellow, B_Green,
    input  Walk, Cnt, CurrStage
  );

  modport slave (
    input  PedReq, NightMode,
    output A_Red, A_Yellow, A_Green,
    output B_Red, B_Yellow, B_Green,
    output Walk, Cnt, CurrStage
  );
endinterface

// File: rtl/tl_countdown.sv
// Stage countdown: reloads on load, else decrements to 0 and holds.
// Ports: clk, rst_n, load, load_val in; cnt, zero out.
module tl_countdown #(
  parameter int               CNT_W   = 6,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= RST_VAL;
    else if (load)    cnt <= load_val;
    else if (!zero)   cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/traffic_intersection.sv
// Two-road intersection controller with pedestrian and night flash.
// Ports: Clk, Rst_n; bus (slave) carries inputs, lamps, Cnt, stage.
module traffic_intersection
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int T_GREEN  = 24,
  parameter int T_YELLOW = 6,
  parameter int T_ALLRED = 2,
  parameter int T_PED    = 10,
  parameter int T_FLASH  = 3
) (
  input logic Clk,
  input logic Rst_n,
  traffic_intersection_if.slave bus
);

  if (!t_fits(T_GREEN, CNT_W) || !t_fits(T_YELLOW, CNT_W) ||
      !t_fits(T_ALLRED, CNT_W) || !t_fits(T_PED, CNT_W) ||
      !t_fits(T_FLASH, CNT_W)) begin : g_t_range
    $error("traffic_intersection: T_* outside 1..2**CNT_W-1");
  end

  stage_e           stage, stage_nxt;
  logic             phase, phase_nxt;
  logic             pend, pend_nxt;
  lamps_t           lamps;
  logic             zero;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  tl_countdown #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_ALLRED))
  ) u_cnt (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (zero),
    .load_val (load_val),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_comb begin
    stage_nxt = stage;
    phase_nxt = phase;
    if (zero) begin
      unique case (stage)
        A_GRN: stage_nxt = A_YEL;
        A_YEL: stage_nxt = CLR_A;
        CLR_A: stage_nxt = bus.NightMode ? FLASH : B_GRN;
        B_GRN: stage_nxt = B_YEL;
        B_YEL: stage_nxt = CLR_B;
        CLR_B: stage_nxt = bus.NightMode ? FLASH :
                           pend ? PED : A_GRN;
        PED:   stage_nxt = A_GRN;
        FLASH: begin
          stage_nxt = bus.NightMode ? FLASH : CLR_B;
          phase_nxt = bus.NightMode ? !phase : 1'b0;
        end
      endcase
    end
    load_val = CNT_W'(load_of(stage_nxt, T_GREEN, T_YELLOW,
                              T_ALLRED, T_PED, T_FLASH));
    // Entering PED consumes the request, even if pressed again.
    pend_nxt = pend | (bus.PedReq && stage != PED);
    if (zero && stage_nxt == PED) pend_nxt = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stage <= CLR_B;
      phase <= 1'b0;
      pend  <= 1'b0;
      lamps <= LAMPS_RST;
    end else begin
      stage <= stage_nxt;
      phase <= phase_nxt;
      pend  <= pend_nxt;
      lamps <= lamps_of(stage_nxt, phase_nxt);
    end
  end

  assign bus.CurrStage = stage;
  assign bus.Cnt       = cnt;
  assign bus.A_Red     = lamps.a_red;
  assign bus.A_Yellow  = lamps.a_yel;
  assign bus.A_Green   = lamps.a_grn;
  assign bus.B_Red     = lamps.b_red;
  assign bus.B_Yellow  = lamps.b_yel;
  assign bus.B_Green   = lamps.b_grn;
  assign bus.Walk      = lamps.walk;

endmodule

// File: tb/tb_traffic_intersection.sv
// Randomized bench for traffic_intersection against a cycle model,
// plus directed dwell, pedestrian, night and reset scenarios.
module tb_traffic_intersection;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  traffic_intersection_if #(.CNT_W(6)) bus ();
  traffic_intersection_if #(.CNT_W(4)) bus2 ();

  traffic_intersection dut (
    .Clk (Clk), .Rst_n (Rst_n), .bus (bus)
  );

  traffic_intersection #(
    .CNT_W(4), .T_GREEN(15), .T_YELLOW(6),
    .T_ALLRED(2), .T_PED(10), .T_FLASH(3)
  ) dut2 (
    .Clk (Clk), .Rst_n (Rst_n), .bus (bus2)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int stage;
    int rem;
    int pend;
    int phase;
  } mstate_t;

  // Dwell load per stage, indexed by stage number 0..7.
  int dwell[8] = '{24, 6, 2, 24, 6, 2, 10, 3};
  mstate_t m;

  function automatic mstate_t step(mstate_t s, bit ped,
                                   bit night);
    mstate_t r = s;
    if (ped && s.stage != 6) r.pend = 1;
    if (s.rem > 0) r.rem = s.rem - 1;
    else begin
      case (s.stage)
        0: r.stage = 1;
        1: r.stage = 2;
        2: r.stage = night ? 7 : 3;
        3: r.stage = 4;
        4: r.stage = 5;
        5: r.stage = night ? 7 : (s.pend != 0 ? 6 : 0);
        6: r.stage = 0;
        default: begin
          r.stage = night ? 7 : 5;
          r.phase = night ? 1 - s.phase : 0;
        end
      endcase
      r.rem = dwell[r.stage];
      if (r.stage == 6) r.pend = 0;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_lamps(int s, int ph);
    logic fl;
    fl = (s == 7) && (ph != 0);
    return {s inside {2, 3, 4, 5, 6}, s == 1 || fl, s == 0,
            s inside {0, 1, 2, 5, 6} || fl, s == 4, s == 3,
            s == 6};
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) m <= '{5, 2, 0, 0};
    else m <= step(m, bus.PedReq, bus.NightMode);
  end

  function automatic logic [6:0] lamps_seen();
    return {bus.A_Red, bus.A_Yellow, bus.A_Green, bus.B_Red,
            bus.B_Yellow, bus.B_Green, bus.Walk};
  endfunction

  always @(negedge Clk) begin
    if (chk_en) begin
      check("stage", 32'(bus.CurrStage), m.stage);
      check("cnt", 32'(bus.Cnt), m.rem);
      check("lamps", 32'(lamps_seen()),
            32'(exp_lamps(m.stage, m.phase)));
    end
  end

  task automatic wait_stage(int s, int lim, string tag);
    int n = 0;
    while (32'(bus.CurrStage) != s && n < lim) begin
      n++;
      @(negedge Clk);
    end
    check(tag, 32'(bus.CurrStage), s);
  endtask

  task automatic run_len(int s, output int n);
    n = 0;
    while (32'(bus.CurrStage) == s && n < 100) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic rst_pulse();
    #2 Rst_n = 1'b0;
    #1;
    check("rst_stage", 32'(bus.CurrStage), 5);
    check("rst_cnt", 32'(bus.Cnt), 2);
    check("rst_lamps", 32'(lamps_seen()), 32'(7'b1001000));
    #1 Rst_n = 1'b1;
  endtask

  int seq[70];
  int seq2[70];
  int rs[$];
  int rl[$];
  int n, ones, diff, guard;

  initial begin
    bus.PedReq = 1'b0;
    bus.NightMode = 1'b0;
    bus2.PedReq = 1'b0;
    bus2.NightMode = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_stage", 32'(bus.CurrStage), 5);
    check("reset_cnt", 32'(bus.Cnt), 2);
    check("reset_lamps", 32'(lamps_seen()), 32'(7'b1001000));
    Rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 70; i++) begin
      seq[i] = 32'(bus.CurrStage);
      seq2[i] = 32'(bus2.CurrStage);
      if (i == 3) check("grn_first_cnt", 32'(bus.Cnt), 24);
      @(negedge Clk);
    end
    for (int i = 0; i < 70; i++) begin
      if (i == 0 || seq[i] != seq[i-1]) begin
        rs.push_back(seq[i]);
        rl.push_back(1);
      end else rl[$] = rl[$] + 1;
    end
    check("dw_clrb", 32'(rl[0]), 3);
    check("dw_agrn", 32'(rl[1]), 25);
    check("dw_ayel", 32'(rl[2]), 7);
    check("dw_clra", 32'(rl[3]), 3);
    check("dw_bgrn", 32'(rl[4]), 25);
    check("order_b", 32'(rs[4]), 3);
    n = 0;
    for (int i = 3; i < 70 && seq2[i] == 0; i++) n++;
    check("w4_green", 32'(n), 16);

    wait_stage(3, 200, "wait_bgrn");
    bus.PedReq = 1'b1;
    @(negedge Clk);
    bus.PedReq = 1'b0;
    wait_stage(6, 200, "wait_ped");
    check("ped_walk", 32'(bus.Walk), 1);
    run_len(6, n);
    check("ped_len", 32'(n), 11);
    check("after_ped", 32'(bus.CurrStage), 0);
    @(negedge Clk);
    check("no_ped_again", 32'(bus.CurrStage), 0);

    bus.NightMode = 1'b1;
    wait_stage(7, 200, "wait_flash");
    ones = 0;
    diff = 0;
    for (int i = 0; i < 8; i++) begin
      ones += int'(bus.A_Yellow);
      if (bus.A_Yellow != bus.B_Red) diff++;
      @(negedge Clk);
    end
    check("flash_ones", 32'(ones), 4);
    check("flash_bred", 32'(diff), 0);
    bus.NightMode = 1'b0;
    wait_stage(5, 50, "wait_flash_exit");
    run_len(5, n);
    check("flash_clrb", 32'(n), 3);
    check("flash_agrn", 32'(bus.CurrStage), 0);

    wait_stage(3, 200, "wait_bgrn2");
    bus.PedReq = 1'b1;
    @(negedge Clk);
    bus.PedReq = 1'b0;
    guard = 0;
    while (!(bus.CurrStage == 3'd4 && bus.Cnt == 6'd3) &&
           guard < 200) begin
      guard++;
      @(negedge Clk);
    end
    check("wait_byel3", 32'(bus.Cnt), 3);
    rst_pulse();
    @(negedge Clk);
    run_len(5, n);
    check("rst_clrb_rest", 32'(n), 2);
    check("rst_pend_clr", 32'(bus.CurrStage), 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      bus.PedReq = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0)
        bus.NightMode = ~bus.NightMode;
      if ($urandom_range(0, 999) == 0) rst_pulse();
    end
    @(negedge Clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
